// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: 4x4 keypad scanner with debounce, two-operand hex entry and 4-digit segment display
module keypad_entry_ctrl #(
    parameter int SCAN_TICKS   = 50000,
    parameter int SETTLE_TICKS = 8,
    parameter int DEB_SCANS    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    input  logic        sel_op,
    input  logic        clr,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] num1,
    output logic [15:0] num2,
    output logic        full1,
    output logic        full2,
    output logic [31:0] hex_n
);
    localparam int TW = SCAN_TICKS > 1 ? $clog2(SCAN_TICKS) : 1;
    localparam int CW = $clog2(DEB_SCANS + 1);
    // indexed by {slot, row}, R1 first
    localparam logic [15:0][3:0] KEYMAP = {4'hD, 4'hC, 4'hB, 4'hA, 4'hE, 4'h9, 4'h6, 4'h3,
                                           4'h0, 4'h8, 4'h5, 4'h2, 4'hF, 4'h7, 4'h4, 4'h1};
    localparam logic [15:0][7:0] GLYPH = {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
                                          8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};

    typedef enum logic [1:0] {IDLE, ARMING, PRESSED, RELEASING} state_t;

    state_t          state;
    logic [TW-1:0]   tick;
    logic [1:0]      slot;
    logic            acc_hit, acc_bad;
    logic [3:0]      acc_code;
    logic [3:0]      cand;
    logic [CW-1:0]   cnt;
    logic [2:0]      cnt1, cnt2;
    logic [3:0]      rows_low;
    logic [1:0]      r;
    logic            one_row, sample, slot_end, scan_end, hit_now, bad_now, res_one;
    logic [3:0]      res_code;
    logic [15:0]     cur_num;
    logic [2:0]      cur_cnt;
    logic [31:0]     hex_d;

    assign col   = ~(4'b1000 >> slot);
    assign full1 = cnt1 == 3'd4;
    assign full2 = cnt2 == 3'd4;

    always_comb begin
        rows_low = ~row;
        one_row  = rows_low != 4'd0 && (rows_low & (rows_low - 4'd1)) == 4'd0;
        r        = rows_low[3] ? 2'd0 : rows_low[2] ? 2'd1 : rows_low[1] ? 2'd2 : 2'd3;
        sample   = tick == TW'(SETTLE_TICKS);
        slot_end = tick == TW'(SCAN_TICKS - 1);
        scan_end = slot_end && slot == 2'd3;
        hit_now  = sample && one_row;
        bad_now  = sample && rows_low != 4'd0 && !one_row;
        // a second single-row hit anywhere in the scan makes it ambiguous
        res_one  = (acc_hit | hit_now) && !(acc_bad | bad_now | (acc_hit & hit_now));
        res_code = hit_now ? KEYMAP[{slot, r}] : acc_code;
        cur_num  = sel_op ? num2 : num1;
        cur_cnt  = sel_op ? cnt2 : cnt1;
        hex_d    = '1;
        for (int i = 0; i < 4; i++)
            hex_d[8*i +: 8] = 3'(i) < cur_cnt ? GLYPH[cur_num[4*i +: 4]] : 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick     <= '0;
            slot     <= '0;
            acc_hit  <= 1'b0;
            acc_bad  <= 1'b0;
            acc_code <= '0;
        end else begin
            tick     <= slot_end ? '0 : tick + TW'(1);
            slot     <= slot_end ? slot + 2'd1 : slot;
            acc_hit  <= !scan_end && (acc_hit | hit_now);
            acc_bad  <= !scan_end && (acc_bad | bad_now | (acc_hit & hit_now));
            acc_code <= res_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
        end else begin
            key_valid <= 1'b0;
            if (scan_end) begin
                case (state)
                    IDLE: if (res_one) begin
                        state <= ARMING;
                        cand  <= res_code;
                        cnt   <= CW'(1);
                    end
                    ARMING: if (!res_one) begin
                        state <= IDLE;
                    end else if (res_code != cand) begin
                        cand <= res_code;
                        cnt  <= CW'(1);
                    end else if (cnt >= CW'(DEB_SCANS - 1)) begin
                        state     <= PRESSED;
                        key_code  <= cand;
                        key_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                    PRESSED: if (!res_one) begin
                        state <= RELEASING;
                        cnt   <= CW'(1);
                    end
                    RELEASING: if (res_one) begin
                        state <= PRESSED;
                    end else if (cnt >= CW'(DEB_SCANS - 1)) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num1 <= '0;
            num2 <= '0;
            cnt1 <= '0;
            cnt2 <= '0;
        end else if (clr) begin
            num1 <= sel_op ? num1 : 16'd0;
            cnt1 <= sel_op ? cnt1 : 3'd0;
            num2 <= sel_op ? 16'd0 : num2;
            cnt2 <= sel_op ? 3'd0 : cnt2;
        end else if (key_valid) begin
            if (!sel_op && !full1) begin
                num1 <= {num1[11:0], key_code};
                cnt1 <= cnt1 + 3'd1;
            end
            if (sel_op && !full2) begin
                num2 <= {num2[11:0], key_code};
                cnt2 <= cnt2 + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) hex_n <= '1;
        else     hex_n <= hex_d;
    end
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb_keypad_entry_ctrl: keypad matrix model driving the controller; checks scans, key events, operands, display
module tb_keypad_entry_ctrl;
    localparam int ST = 16, SE = 4, DB = 2;
    localparam int KEY[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 15, 0, 14, 13};
    localparam logic [7:0] GLY[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                       8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic clk = 1'b0, rst = 1'b1, sel_op = 1'b0, clr = 1'b0;
    logic [3:0] row, col, key_code;
    logic key_valid, full1, full2;
    logic [15:0] num1, num2;
    logic [31:0] hex_n;
    logic [15:0] held = '0;

    int tests = 0, fails = 0;
    int hist[$];
    bit pressed;
    int m_code, pend;
    int m_num[2], m_cnt[2];
    bit m_sel;

    keypad_entry_ctrl #(.SCAN_TICKS(ST), .SETTLE_TICKS(SE), .DEB_SCANS(DB)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .sel_op(sel_op), .clr(clr),
        .key_valid(key_valid), .key_code(key_code), .num1(num1), .num2(num2),
        .full1(full1), .full2(full2), .hex_n(hex_n)
    );

    always #5 clk = ~clk;

    // held[r*4+c]: key at row R(r+1), column C(c+1) pulls its row low while its column is driven
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (held[r*4+c] && !col[3-c]) row[3-r] = 1'b0;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_hex(input int n, input int c);
        logic [31:0] h;
        for (int i = 0; i < 4; i++) h[8*i +: 8] = i < c ? GLY[(n >> (4*i)) & 15] : 8'hFF;
        return h;
    endfunction

    // called at a negedge; leaves the DUT freshly reset with the next posedge as scan tick 1
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        hist.delete();
        pressed = 0;
        m_code = 0;
        pend = -1;
        m_num = '{0, 0};
        m_cnt = '{0, 0};
        check("rst_col", {28'd0, col}, 32'h7);
        check("rst_kv", {31'd0, key_valid}, 0);
        check("rst_kcode", {28'd0, key_code}, 0);
        check("rst_nums", {num1, num2}, 0);
        check("rst_full", {30'd0, full1, full2}, 0);
        check("rst_hex", hex_n, 32'hFFFF_FFFF);
    endtask

    // one full 4-slot scan with a fixed set of held keys; clr_at: -1 none, 0 with pending entry, else that cycle
    task automatic run_scan(input logic [15:0] mask, input bit sel, input int clr_at);
        int kv = 0, cls = -1, e = -1;
        bit colbad = 0;
        held = mask;
        if (clr_at == 0) begin
            m_num[m_sel] = 0;
            m_cnt[m_sel] = 0;
        end else if (pend >= 0 && m_cnt[m_sel] < 4) begin
            m_num[m_sel] = (m_num[m_sel] * 16 + pend) % 65536;
            m_cnt[m_sel]++;
        end
        pend = -1;
        for (int n = 1; n <= 4 * ST; n++) begin
            clr = clr_at >= 0 && n == clr_at + 1;
            if (n == 5) sel_op = sel;
            @(posedge clk);
            @(negedge clk);
            if (n == 5) m_sel = sel;
            if (clr_at > 0 && n == clr_at + 1) begin
                m_num[m_sel] = 0;
                m_cnt[m_sel] = 0;
            end
            if (key_valid) kv++;
            if (col !== ~(4'b1000 >> ((n / ST) % 4))) colbad = 1;
        end
        clr = 1'b0;
        if ($countones(mask) == 1)
            for (int i = 0; i < 16; i++) if (mask[i]) cls = KEY[i];
        hist.push_back(cls);
        if (hist.size() >= DB) begin
            bit same = 1, none = 1;
            int last = hist[hist.size()-1];
            for (int j = 0; j < DB; j++) begin
                int v = hist[hist.size()-1-j];
                if (v != last || v < 0) same = 0;
                if (v >= 0) none = 0;
            end
            if (!pressed && same) begin
                e = last;
                pressed = 1;
            end else if (pressed && none) begin
                pressed = 0;
            end
        end
        if (e >= 0) m_code = e;
        pend = e;
        check("col_seq", {31'd0, colbad}, 0);
        check("kv_count", kv, e >= 0 ? 1 : 0);
        check("key_code", {28'd0, key_code}, m_code);
        check("num1", {16'd0, num1}, m_num[0]);
        check("num2", {16'd0, num2}, m_num[1]);
        check("full1", {31'd0, full1}, m_cnt[0] == 4 ? 1 : 0);
        check("full2", {31'd0, full2}, m_cnt[1] == 4 ? 1 : 0);
        check("hex_n", hex_n, exp_hex(m_num[m_sel], m_cnt[m_sel]));
    endtask

    task automatic press(input int idx, input bit sel);
        logic [15:0] m = 16'd1 << idx;
        for (int i = 0; i < 3; i++) run_scan(m, sel, -1);
        for (int i = 0; i < 2; i++) run_scan('0, sel, -1);
    endtask

    initial begin
        m_sel = 0;
        do_reset();
        for (int i = 0; i < 3; i++) run_scan('0, 0, -1);
        for (int i = 0; i < 14; i++) run_scan(16'h0020, 0, -1);
        check("dir_num1_5", {16'd0, num1}, 32'h0005);
        check("dir_hex_5", hex_n, 32'hFFFF_FF92);
        for (int i = 0; i < 3; i++) run_scan('0, 0, -1);
        run_scan('0, 0, 10);
        press(0, 0);
        press(1, 0);
        press(2, 0);
        press(3, 0);
        check("dir_num1_123A", {16'd0, num1}, 32'h123A);
        check("dir_hex_123A", hex_n, 32'hF9A4_B088);
        press(8, 0);
        check("dir_num1_full", {15'd0, full1, num1}, 32'h1123A);
        press(8, 1);
        press(14, 1);
        check("dir_num2_7E", {num1, num2}, 32'h123A_007E);
        run_scan('0, 1, 10);
        check("dir_clr2", {15'd0, full2, num2}, 0);
        check("dir_clr2_hex", hex_n, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) run_scan(16'h0005, 1, -1);
        run_scan(16'h0400, 1, -1);
        run_scan('0, 1, -1);
        run_scan('0, 1, -1);
        run_scan(16'h0010, 0, -1);
        do_reset();
        for (int i = 0; i < 3; i++) run_scan(16'h0010, 0, -1);
        check("dir_after_rst_4", {16'd0, num1}, 32'h0004);
        run_scan('0, 0, 0);
        run_scan('0, 0, -1);
        for (int ep = 0; ep < 40; ep++) begin
            int t = $urandom_range(0, 9);
            int len = $urandom_range(1, 4);
            logic [15:0] m = '0;
            if (t >= 4) m[$urandom_range(0, 15)] = 1'b1;
            if (t == 9) m[$urandom_range(0, 15)] = 1'b1;
            for (int i = 0; i < len; i++) begin
                int k = $urandom_range(0, 9);
                run_scan(m, 1'($urandom_range(0, 1)), k == 0 ? 0 : k == 1 ? 10 : -1);
            end
            if ($urandom_range(0, 24) == 0) do_reset();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
